// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - memory-stage load/store bus sequencer
//
// Purpose:
//   Checks load/store alignment, builds byte enables and replicated store
//   data, and runs one req/ack bus transaction per memory op. It stalls the
//   pipeline while the transaction is in flight, then hands the raw read
//   word, byte offset and load type to the load-extension stage.
//
// Ports:
//   clk, reset                    clock (rising edge), async active-high reset
//   Load, Store, LdType, StType   MEM-stage op (both set = store)
//   Addr, WData, Flush            effective address, store source, squash
//   Stall                         freeze PC..EX/MEM
//   AdEL, AdES                    combinational misalignment flags
//   BusReq/BusWE/BusBE/BusAddr/BusWData   registered bus request
//   BusRData, BusAck              bus read word and completion
//   BusErr                        one-cycle timeout pulse
//   DataW, AddrLo, LoadTypeO      captured load result for extension stage
//   RdValid                       one-cycle pulse marking the capture valid
//
// Optional feature macro: DM_BUS_TIMEOUT_EN (abort WAIT after TIMEOUT_CYCLES).

module dm_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Load,
  input  logic        Store,
  input  logic [2:0]  LdType,
  input  logic [1:0]  StType,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        Flush,
  output logic        Stall,
  output logic        AdEL,
  output logic        AdES,
  output logic        BusReq,
  output logic        BusWE,
  output logic [3:0]  BusBE,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  input  logic [31:0] BusRData,
  input  logic        BusAck,
  output logic        BusErr,
  output logic [31:0] DataW,
  output logic [1:0]  AddrLo,
  output logic [2:0]  LoadTypeO,
  output logic        RdValid
);

  // The counter must be able to hold TIMEOUT_CYCLES-1; an illegal pairing
  // elaborates this empty named block so it shows up in the hierarchy.
  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : gBadTimeoutWidth
  end

  typedef enum logic [1:0] {
    sIdle = 2'd0,
    sWait = 2'd1,
    sDone = 2'd2
  } stateT;

  stateT       state, nextState;
  logic        isStore, isLoad, op;
  logic        wordAcc, halfAcc, misaligned, launch, timeout;
  logic        opIsLoad;
  logic [3:0]  beNext;
  logic [31:0] wdNext;

  // Store wins when both strobes are set.
  assign isStore = Store;
  assign isLoad  = Load & ~Store;
  assign op      = Load | Store;

  // Access size; unused encodings are treated as word accesses.
  always_comb begin
    wordAcc = 1'b0;
    halfAcc = 1'b0;
    if (isStore) begin
      wordAcc = (StType == 2'd0) | (StType == 2'd3);
      halfAcc = (StType == 2'd1);
    end else begin
      wordAcc = (LdType == 3'd0) | (LdType > 3'd4);
      halfAcc = (LdType == 3'd1) | (LdType == 3'd2);
    end
  end

  assign misaligned = (wordAcc & (Addr[1:0] != 2'b00)) | (halfAcc & Addr[0]);
  assign AdEL       = isLoad & misaligned;
  assign AdES       = isStore & misaligned;
  assign launch     = op & ~misaligned & ~Flush;

  // Byte lanes and lane-replicated write data; loads read the full word.
  always_comb begin
    beNext = 4'b0000;
    wdNext = 32'h0;
    if (isStore) begin
      case (StType)
        2'd1: begin
          beNext = Addr[1] ? 4'b1100 : 4'b0011;
          wdNext = {2{WData[15:0]}};
        end
        2'd2: begin
          beNext = 4'b0001 << Addr[1:0];
          wdNext = {4{WData[7:0]}};
        end
        default: begin
          beNext = 4'b1111;
          wdNext = WData;
        end
      endcase
    end
  end

`ifdef DM_BUS_TIMEOUT_EN
  logic [TO_W-1:0] toCnt;
  logic            busErrQ;

  // toCnt counts WAIT cycles already spent, so the abort lands at the end
  // of the TIMEOUT_CYCLES-th WAIT cycle. An ack that same cycle wins.
  assign timeout = (state == sWait) & ~BusAck &
                   (toCnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign BusErr  = busErrQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toCnt <= '0;
    end else if (state == sIdle && launch) begin
      toCnt <= '0;
    end else if (state == sWait) begin
      toCnt <= toCnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign BusErr  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= sIdle;
    else       state <= nextState;
  end

  // Stall is low in DONE so the pipeline advances exactly once per op.
  always_comb begin
    nextState = state;
    Stall     = 1'b0;
    case (state)
      sIdle: begin
        if (launch) begin
          nextState = sWait;
          Stall     = 1'b1;
        end
      end
      sWait: begin
        Stall = 1'b1;
        if (BusAck || timeout) nextState = sDone;
      end
      sDone:   nextState = sIdle;
      default: nextState = sIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BusReq    <= 1'b0;
      BusWE     <= 1'b0;
      BusBE     <= 4'b0000;
      BusAddr   <= 32'h0;
      BusWData  <= 32'h0;
      DataW     <= 32'h0;
      AddrLo    <= 2'b00;
      LoadTypeO <= 3'd0;
      RdValid   <= 1'b0;
      opIsLoad  <= 1'b0;
`ifdef DM_BUS_TIMEOUT_EN
      busErrQ   <= 1'b0;
`endif
    end else begin
      RdValid <= 1'b0;
`ifdef DM_BUS_TIMEOUT_EN
      busErrQ <= 1'b0;
`endif
      case (state)
        sIdle: begin
          if (launch) begin
            BusReq    <= 1'b1;
            BusWE     <= isStore;
            BusBE     <= beNext;
            BusAddr   <= {Addr[31:2], 2'b00};
            BusWData  <= wdNext;
            AddrLo    <= Addr[1:0];
            LoadTypeO <= LdType;
            opIsLoad  <= isLoad;
          end
        end
        sWait: begin
          if (BusAck) begin
            BusReq <= 1'b0;
            BusWE  <= 1'b0;
            BusBE  <= 4'b0000;
            // DataW is left alone on stores so the last load result persists.
            if (opIsLoad) begin
              DataW   <= BusRData;
              RdValid <= 1'b1;
            end
          end
`ifdef DM_BUS_TIMEOUT_EN
          else if (timeout) begin
            BusReq  <= 1'b0;
            BusWE   <= 1'b0;
            BusBE   <= 4'b0000;
            DataW   <= 32'hEEEE_EEEE;
            busErrQ <= 1'b1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - directed self-checking bench for dm_access_ctrl

module tb_dm_access_ctrl;

  logic        clk, reset;
  logic        Load, Store, Flush, BusAck;
  logic [2:0]  LdType;
  logic [1:0]  StType;
  logic [31:0] Addr, WData, BusRData;
  logic        Stall, AdEL, AdES, BusReq, BusWE, BusErr, RdValid;
  logic [3:0]  BusBE;
  logic [31:0] BusAddr, BusWData, DataW;
  logic [1:0]  AddrLo;
  logic [2:0]  LoadTypeO;

  int errors = 0;
  int checks = 0;
  int stallCnt = 0;
  int reqCnt = 0;
  int base, reqBase;

  dm_access_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .Load(Load), .Store(Store), .LdType(LdType),
    .StType(StType), .Addr(Addr), .WData(WData), .Flush(Flush),
    .Stall(Stall), .AdEL(AdEL), .AdES(AdES), .BusReq(BusReq), .BusWE(BusWE),
    .BusBE(BusBE), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusRData(BusRData), .BusAck(BusAck), .BusErr(BusErr), .DataW(DataW),
    .AddrLo(AddrLo), .LoadTypeO(LoadTypeO), .RdValid(RdValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (Stall === 1'b1) stallCnt++;
    if (BusReq === 1'b1) reqCnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    Load = 1'b0; Store = 1'b0; Flush = 1'b0; BusAck = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Load = 1'b0; Store = 1'b0; Flush = 1'b0; BusAck = 1'b0;
    LdType = 3'd0; StType = 2'd0; Addr = 32'h0; WData = 32'h0; BusRData = 32'h0;
    tick(); tick();

    // Reset state
    checkEq("rst_busreq", {31'h0, BusReq}, 32'h0);
    checkEq("rst_stall", {31'h0, Stall}, 32'h0);
    checkEq("rst_be_we", {27'h0, BusWE, BusBE}, 32'h0);
    checkEq("rst_busaddr", BusAddr, 32'h0);
    checkEq("rst_dataw", DataW, 32'h0);
    checkEq("rst_lo_type", {27'h0, AddrLo, LoadTypeO}, 32'h0);
    checkEq("rst_rdv_err", {30'h0, RdValid, BusErr}, 32'h0);
    reset = 1'b0;
    tick();

    // lw 0x100, ack one cycle after request
    base = stallCnt;
    Load = 1'b1; LdType = 3'd0; Addr = 32'h100;
    #1 checkEq("lw_stall_idle", {31'h0, Stall}, 32'h1);
    tick();
    checkEq("lw_req", {26'h0, BusReq, BusWE, BusBE}, 32'h20);
    checkEq("lw_busaddr", BusAddr, 32'h100);
    BusAck = 1'b1; BusRData = 32'h89AB_CDEF;
    tick();
    checkEq("lw_done_req", {30'h0, BusReq, Stall}, 32'h0);
    checkEq("lw_rdvalid", {31'h0, RdValid}, 32'h1);
    checkEq("lw_dataw", DataW, 32'h89AB_CDEF);
    checkEq("lw_lo_type", {27'h0, AddrLo, LoadTypeO}, 32'h0);
    idleInputs();
    tick();
    checkEq("lw_stall_cycles", stallCnt - base, 2);
    checkEq("lw_rdvalid_pulse", {31'h0, RdValid}, 32'h0);

    // Ack while idle is ignored
    BusAck = 1'b1; BusRData = 32'h1111_1111;
    tick(); tick();
    checkEq("idle_ack_dataw", DataW, 32'h89AB_CDEF);
    checkEq("idle_ack_rdv", {30'h0, RdValid, BusReq}, 32'h0);
    BusAck = 1'b0;

    // sb 0x103
    Store = 1'b1; StType = 2'd2; Addr = 32'h103; WData = 32'h0000_00A5;
    #1 checkEq("sb_ades", {31'h0, AdES}, 32'h0);
    tick();
    checkEq("sb_req_we_be", {26'h0, BusReq, BusWE, BusBE}, 32'h38);
    checkEq("sb_wdata", BusWData, 32'hA5A5_A5A5);
    checkEq("sb_busaddr", BusAddr, 32'h100);
    BusAck = 1'b1;
    tick();
    checkEq("sb_done", {29'h0, BusReq, BusWE, RdValid}, 32'h0);
    checkEq("sb_dataw_kept", DataW, 32'h89AB_CDEF);
    checkEq("sb_addrlo", {30'h0, AddrLo}, 32'h3);
    idleInputs();
    tick();

    // Misaligned lh: AdEL, no request, no stall
    base = stallCnt; reqBase = reqCnt;
    Load = 1'b1; LdType = 3'd2; Addr = 32'h101;
    #1 checkEq("lh_adel_ades", {30'h0, AdEL, AdES}, 32'h2);
    tick(); tick(); tick();
    checkEq("lh_no_stall", stallCnt - base, 0);
    checkEq("lh_no_req", reqCnt - reqBase, 0);
    // Byte access never misaligned; word at offset 2 is
    LdType = 3'd4; Addr = 32'h103;
    #1 checkEq("lb_aligned", {30'h0, AdEL, AdES}, 32'h0);
    Load = 1'b0; Store = 1'b1; StType = 2'd0; Addr = 32'h102;
    #1 checkEq("sw_ades", {30'h0, AdEL, AdES}, 32'h1);
    // Both strobes set behaves as a store
    Load = 1'b1; Store = 1'b1; LdType = 3'd3; StType = 2'd0; Addr = 32'h202;
    #1 checkEq("both_is_store", {30'h0, AdEL, AdES}, 32'h1);
    // Flush in IDLE blocks the launch
    Store = 1'b0; LdType = 3'd0; Addr = 32'h200; Flush = 1'b1;
    #1 checkEq("flush_idle_stall", {31'h0, Stall}, 32'h0);
    tick();
    checkEq("flush_idle_req", {31'h0, BusReq}, 32'h0);
    idleInputs();
    tick();

    // sh 0x102, ack in 4th WAIT cycle, Flush during WAIT
    base = stallCnt;
    Store = 1'b1; StType = 2'd1; Addr = 32'h102; WData = 32'h1234_BEEF;
    tick();
    checkEq("sh_be", {28'h0, BusBE}, 32'hC);
    checkEq("sh_wdata", BusWData, 32'hBEEF_BEEF);
    Flush = 1'b1;
    tick(); tick(); tick();
    checkEq("sh_wait_req", {30'h0, BusReq, Stall}, 32'h3);
    BusAck = 1'b1;
    tick();
    checkEq("sh_done_req", {31'h0, BusReq}, 32'h0);
    idleInputs();
    tick();
    checkEq("sh_stall_cycles", stallCnt - base, 5);

    // Reset mid-WAIT, then lbu
    Load = 1'b1; LdType = 3'd0; Addr = 32'h200;
    tick();
    checkEq("rw_req_before", {31'h0, BusReq}, 32'h1);
    reset = 1'b1; Load = 1'b0;
    #1 checkEq("rw_async_drop", {30'h0, BusReq, Stall}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    Load = 1'b1; LdType = 3'd3; Addr = 32'h203;
    tick();
    checkEq("lbu_req", {26'h0, BusReq, BusWE, BusBE}, 32'h20);
    checkEq("lbu_busaddr", BusAddr, 32'h200);
    BusAck = 1'b1; BusRData = 32'h1122_3344;
    tick();
    checkEq("lbu_dataw", DataW, 32'h1122_3344);
    checkEq("lbu_rdv_lo_type", {26'h0, RdValid, AddrLo, LoadTypeO}, 32'h3B);
    idleInputs();
    tick();

    // No ack: timeout behaviour depends on the build
    base = stallCnt;
    Load = 1'b1; LdType = 3'd0; Addr = 32'h300;
`ifdef DM_BUS_TIMEOUT_EN
    begin
      int n;
      n = 0;
      tick();
      while (BusErr !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      checkEq("to_wait_cycles", n, 4);
      checkEq("to_err_rdv_req", {29'h0, BusErr, RdValid, BusReq}, 32'h4);
      checkEq("to_dataw", DataW, 32'hEEEE_EEEE);
      idleInputs();
      tick();
      checkEq("to_err_pulse", {31'h0, BusErr}, 32'h0);
      checkEq("to_stall_cycles", stallCnt - base, 5);
    end
`else
    tick();
    repeat (6) tick();
    checkEq("noto_req_held", {29'h0, BusReq, Stall, BusErr}, 32'h6);
    BusAck = 1'b1; BusRData = 32'h5555_AAAA;
    tick();
    checkEq("noto_dataw", DataW, 32'h5555_AAAA);
    idleInputs();
    tick();
    checkEq("noto_stall_cycles", stallCnt - base, 8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
